// File: rtl/regfile_pkg.sv
// Shared definitions for the register file operand-fetch / writeback controller.
// Optional feature macro: REGFILE_CTRL_BYPASS_EN (writeback forwarding).
package regfile_pkg;

  localparam int DW    = 17;
  localparam int AW    = 3;
  localparam int NREGS = 7;

  // Address 7 is the hard-wired zero register: never busy, reads 0, writes dropped.
  localparam logic [2:0] ZERO_REG = 3'd7;

  // Operand output stage occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per implemented register.
// Optional feature macro: REGFILE_CTRL_BYPASS_EN (a same-cycle writeback
// to a queried address cancels its hazard).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW    = regfile_pkg::AW,
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [AW-1:0] dst,
  input  logic          dst_en,
  output logic          hazard
);

  localparam int NSLOT = 1 << AW;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NSLOT-1:0] busy_ext;
  logic             src1_hz, src2_hz, dst_hz;

  // Unimplemented addresses (the zero register) are padded as never busy.
  assign busy_ext = {{(NSLOT-NREGS){1'b0}}, busy_q};

  // Hazard query for both sources and the optional destination.
  always_comb begin
    src1_hz = busy_ext[src1];
    src2_hz = busy_ext[src2];
    dst_hz  = busy_ext[dst];
`ifdef REGFILE_CTRL_BYPASS_EN
    if (clr_en && (clr_addr == src1)) src1_hz = 1'b0;
    if (clr_en && (clr_addr == src2)) src2_hz = 1'b0;
    if (clr_en && (clr_addr == dst))  dst_hz  = 1'b0;
`endif
    hazard = src1_hz | src2_hz | (dst_en & dst_hz);
  end

  // Next busy bits: writeback clears, a new reservation sets and wins, flush wipes all.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (clr_en && (clr_addr == AW'(i))) busy_d[i] = 1'b0;
      if (set_en && (set_addr == AW'(i))) busy_d[i] = 1'b1;
    end
    if (flush) busy_d = '0;
  end

  // Busy register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Operand-fetch and writeback controller for the 7x17 dual-read, single-write
// register file, with a registered valid/ready operand stage toward execute.
// Optional feature macro: REGFILE_CTRL_BYPASS_EN (forward wb_data to sources).
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int DW    = regfile_pkg::DW,
  parameter int AW    = regfile_pkg::AW,
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_src1,
  input  logic [AW-1:0] req_src2,
  input  logic [AW-1:0] req_dst,
  input  logic          req_dst_en,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [AW-1:0] op_dst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [AW-1:0] rf_ra1,
  output logic [AW-1:0] rf_ra2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic [AW-1:0] rf_wr,
  output logic [DW-1:0] rf_wrd,
  output logic          rf_we
);

  stage_state_t  state_q, state_d;
  logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [AW-1:0] op_dst_q, op_dst_d;
  logic [DW-1:0] sel_a, sel_b;
  logic          hazard, stage_free, accept, rsv_en;

  assign rf_ra1 = req_src1;
  assign rf_ra2 = req_src2;
  assign rf_wr  = wb_addr;
  assign rf_wrd = wb_data;
  assign rf_we  = wb_valid & (wb_addr != ZERO_REG);

  assign stage_free = (state_q == EMPTY) | op_ready;
  assign req_ready  = rst_n & ~flush & stage_free & ~hazard;
  assign accept     = req_valid & req_ready;
  assign rsv_en     = accept & req_dst_en & (req_dst != ZERO_REG);

  regfile_scoreboard #(
    .AW    (AW),
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .set_en   (rsv_en),
    .set_addr (req_dst),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .src1     (req_src1),
    .src2     (req_src2),
    .dst      (req_dst),
    .dst_en   (req_dst_en),
    .hazard   (hazard)
  );

  // Operand source selection: zero register forced to 0, optional writeback forwarding.
  always_comb begin
    sel_a = rf_rd1;
    sel_b = rf_rd2;
`ifdef REGFILE_CTRL_BYPASS_EN
    if (wb_valid && (wb_addr == req_src1)) sel_a = wb_data;
    if (wb_valid && (wb_addr == req_src2)) sel_b = wb_data;
`endif
    if (req_src1 == ZERO_REG) sel_a = '0;
    if (req_src2 == ZERO_REG) sel_b = '0;
  end

  // Output stage state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Output stage next state: flush empties, accept fills, consume without accept drains.
  always_comb begin
    state_d = state_q;
    if (flush)                              state_d = EMPTY;
    else if (accept)                        state_d = FULL;
    else if ((state_q == FULL) && op_ready) state_d = EMPTY;
  end

  // Output stage outputs decoded from the state.
  always_comb begin
    op_valid = (state_q == FULL);
  end

  // Operand payload captures only on accept and otherwise holds.
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_dst_d = op_dst_q;
    if (accept) begin
      op_a_d   = sel_a;
      op_b_d   = sel_b;
      op_dst_d = req_dst;
    end
  end

  // Operand payload registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_dst_q <= '0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_dst_q <= op_dst_d;
    end
  end

  assign op_a   = op_a_q;
  assign op_b   = op_b_q;
  assign op_dst = op_dst_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed, table-driven bench for regfile_ctrl with a behavioural register file.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_src1, req_src2, req_dst;
  logic        req_dst_en;
  logic        op_valid;
  logic        op_ready;
  logic [16:0] op_a, op_b;
  logic [2:0]  op_dst;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [16:0] wb_data;
  logic [2:0]  rf_ra1, rf_ra2, rf_wr;
  logic [16:0] rf_rd1, rf_rd2, rf_wrd;
  logic        rf_we;

  int tests = 0;
  int fails = 0;

  logic [16:0] rf_mem [0:6];

  typedef struct {
    logic        req_valid;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [2:0]  dst;
    logic        dst_en;
    logic        op_ready;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [16:0] wb_data;
    logic        flush;
    logic        exp_ready;
    logic        exp_we;
    logic        exp_valid;
    logic [16:0] exp_a;
    logic [16:0] exp_b;
    logic [2:0]  exp_dst;
    logic [6:0]  exp_busy;
  } vec_t;

  vec_t vecs [0:14];

  always #5 clk = ~clk;

  regfile_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_dst    (req_dst),
    .req_dst_en (req_dst_en),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_dst     (op_dst),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .rf_wr      (rf_wr),
    .rf_wrd     (rf_wrd),
    .rf_we      (rf_we)
  );

  // Unimplemented address 7 returns junk so the controller's zero forcing is visible.
  assign rf_rd1 = (rf_ra1 < 3'd7) ? rf_mem[rf_ra1] : 17'h1FFFF;
  assign rf_rd2 = (rf_ra2 < 3'd7) ? rf_mem[rf_ra2] : 17'h1FFFF;

  // Behavioural register file write port.
  always @(posedge clk) begin
    if (rf_we && (rf_wr < 3'd7)) rf_mem[rf_wr] <= rf_wrd;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid  = v.req_valid;
    req_src1   = v.src1;
    req_src2   = v.src2;
    req_dst    = v.dst;
    req_dst_en = v.dst_en;
    op_ready   = v.op_ready;
    wb_valid   = v.wb_valid;
    wb_addr    = v.wb_addr;
    wb_data    = v.wb_data;
    flush      = v.flush;
  endtask

  initial begin
    rf_mem[0] = 17'h00005; rf_mem[1] = 17'h1ABCD; rf_mem[2] = 17'h00222;
    rf_mem[3] = 17'h00333; rf_mem[4] = 17'h00444; rf_mem[5] = 17'h00555;
    rf_mem[6] = 17'h00666;

    //          rv  s1    s2    dst   en  ordy wbv  wba   wbd        fl   rdy  we   val  a          b          dst   busy
    vecs[0]  = '{1, 3'd0, 3'd1, 3'd2, 1, 0,   0,   3'd0, 17'h00000, 0,   1,   0,   1,   17'h00005, 17'h1ABCD, 3'd2, 7'h04};
    vecs[1]  = '{1, 3'd2, 3'd0, 3'd3, 0, 1,   0,   3'd0, 17'h00000, 0,   0,   0,   0,   17'h00005, 17'h1ABCD, 3'd2, 7'h04};
    vecs[2]  = '{1, 3'd2, 3'd0, 3'd3, 0, 1,   1,   3'd2, 17'h0F0F0, 0,   0,   1,   0,   17'h00005, 17'h1ABCD, 3'd2, 7'h00};
    vecs[3]  = '{1, 3'd2, 3'd0, 3'd3, 0, 1,   0,   3'd0, 17'h00000, 0,   1,   0,   1,   17'h0F0F0, 17'h00005, 3'd3, 7'h00};
    vecs[4]  = '{1, 3'd4, 3'd5, 3'd6, 1, 0,   0,   3'd0, 17'h00000, 0,   0,   0,   1,   17'h0F0F0, 17'h00005, 3'd3, 7'h00};
    vecs[5]  = '{1, 3'd4, 3'd5, 3'd6, 1, 0,   0,   3'd0, 17'h00000, 0,   0,   0,   1,   17'h0F0F0, 17'h00005, 3'd3, 7'h00};
    vecs[6]  = '{1, 3'd4, 3'd5, 3'd6, 1, 0,   0,   3'd0, 17'h00000, 0,   0,   0,   1,   17'h0F0F0, 17'h00005, 3'd3, 7'h00};
    vecs[7]  = '{1, 3'd4, 3'd5, 3'd6, 1, 1,   0,   3'd0, 17'h00000, 0,   1,   0,   1,   17'h00444, 17'h00555, 3'd6, 7'h40};
    vecs[8]  = '{1, 3'd6, 3'd0, 3'd1, 1, 1,   0,   3'd0, 17'h00000, 0,   0,   0,   0,   17'h00444, 17'h00555, 3'd6, 7'h40};
    vecs[9]  = '{1, 3'd7, 3'd3, 3'd7, 1, 1,   1,   3'd7, 17'h1FFFF, 0,   1,   0,   1,   17'h00000, 17'h00333, 3'd7, 7'h40};
    vecs[10] = '{1, 3'd7, 3'd7, 3'd0, 1, 1,   0,   3'd0, 17'h00000, 0,   1,   0,   1,   17'h00000, 17'h00000, 3'd0, 7'h41};
    vecs[11] = '{1, 3'd1, 3'd2, 3'd3, 1, 1,   0,   3'd0, 17'h00000, 0,   1,   0,   1,   17'h1ABCD, 17'h0F0F0, 3'd3, 7'h49};
    vecs[12] = '{1, 3'd3, 3'd3, 3'd4, 1, 0,   1,   3'd5, 17'h12345, 1,   0,   1,   0,   17'h1ABCD, 17'h0F0F0, 3'd3, 7'h00};
    vecs[13] = '{1, 3'd3, 3'd5, 3'd4, 1, 0,   0,   3'd0, 17'h00000, 0,   1,   0,   1,   17'h00333, 17'h12345, 3'd4, 7'h10};
    vecs[14] = '{1, 3'd0, 3'd1, 3'd4, 1, 1,   0,   3'd0, 17'h00000, 0,   0,   0,   0,   17'h00333, 17'h12345, 3'd4, 7'h10};

    // Reset with a request already presented.
    rst_n = 1'b0;
    applyStimulus('{1, 3'd0, 3'd1, 3'd2, 1, 0, 0, 3'd0, 17'h0, 0, 0, 0, 0, 17'h0, 17'h0, 3'd0, 7'h0});
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset.req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("reset.op_valid", 32'(op_valid), 32'd0);
    checkOutput("reset.op_a",     32'(op_a),     32'd0);
    checkOutput("reset.op_b",     32'(op_b),     32'd0);
    checkOutput("reset.op_dst",   32'(op_dst),   32'd0);
    checkOutput("reset.busy",     32'(dut.u_scoreboard.busy_q), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("v%0d.rf_we", i),     32'(rf_we),     32'(vecs[i].exp_we));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.op_valid", i), 32'(op_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d.op_a", i),     32'(op_a),     32'(vecs[i].exp_a));
      checkOutput($sformatf("v%0d.op_b", i),     32'(op_b),     32'(vecs[i].exp_b));
      checkOutput($sformatf("v%0d.op_dst", i),   32'(op_dst),   32'(vecs[i].exp_dst));
      checkOutput($sformatf("v%0d.busy", i),     32'(dut.u_scoreboard.busy_q), 32'(vecs[i].exp_busy));
    end

    // Reset while a request is stalled on busy register 4.
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus('{1, 3'd4, 3'd4, 3'd5, 1, 0, 0, 3'd0, 17'h0, 0, 0, 0, 0, 17'h0, 17'h0, 3'd0, 7'h0});
    #1;
    checkOutput("midrst.req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst.op_valid", 32'(op_valid), 32'd0);
    checkOutput("midrst.op_a",     32'(op_a),     32'd0);
    checkOutput("midrst.busy",     32'(dut.u_scoreboard.busy_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postrst.req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("postrst.op_valid", 32'(op_valid), 32'd1);
    checkOutput("postrst.op_a",     32'(op_a),     32'h00444);
    checkOutput("postrst.op_b",     32'(op_b),     32'h00444);
    checkOutput("postrst.op_dst",   32'(op_dst),   32'd5);
    checkOutput("postrst.busy",     32'(dut.u_scoreboard.busy_q), 32'h20);

    @(negedge clk);
    req_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
